// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search controller driving an external magnitude comparator
// Optional feature macro: SAR_SEARCH_EARLY_EXIT_EN (finish as soon as the comparator reports EQ)
module sar_search #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [N-1:0]             guess,
    input  logic                     cmp_gt,
    input  logic                     cmp_lt,
    input  logic                     cmp_eq,
    output logic                     busy,
    output logic                     done,
    output logic [N-1:0]             result,
    output logic [$clog2(N+1)-1:0]   steps,
    output logic                     cmp_err
);

    localparam int SW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE_N = N'(1);
    localparam logic [N-1:0] MSB_N = ONE_N << (N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   guess_q, guess_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   result_q, result_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [SW-1:0]  steps_q, steps_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cmp_err_q, cmp_err_d;

    logic           code_bad;
    logic           keep;
    logic           take_eq;
    logic [N-1:0]   kept;
    logic [N-1:0]   next_bit;

    // Comparator decode: EQ > GT > LT, no flag at all behaves as LT; anything but one-hot is flagged
    always_comb begin
        code_bad = !$onehot({cmp_gt, cmp_lt, cmp_eq});
        keep     = cmp_eq | cmp_gt;
        kept     = keep ? guess_q : acc_q;
        next_bit = ONE_N << (idx_q - IW'(1));
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        take_eq  = cmp_eq;
`else
        take_eq  = 1'b0;
`endif
    end

    // Next-state and datapath: one trial bit resolved per TRIAL cycle, MSB first
    always_comb begin
        state_d   = state_q;
        guess_d   = guess_q;
        acc_d     = acc_q;
        result_d  = result_q;
        idx_d     = idx_q;
        steps_d   = steps_q;
        cmp_err_d = cmp_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    idx_d     = IW'(N - 1);
                    guess_d   = MSB_N;
                    steps_d   = '0;
                    cmp_err_d = 1'b0;
                    state_d   = TRIAL;
                end
            end
            TRIAL: begin
                acc_d   = kept;
                steps_d = steps_q + SW'(1);
                if (code_bad) begin
                    cmp_err_d = 1'b1;
                end
                if (take_eq) begin
                    result_d = guess_q;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    result_d = kept;
                    state_d  = DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    guess_d = kept | next_bit;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == TRIAL);
        done_d = (state_d == DONE);
    end

    // State and registered outputs; reset aborts any search in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            guess_q   <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            idx_q     <= '0;
            steps_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            guess_q   <= guess_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            idx_q     <= idx_d;
            steps_q   <= steps_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cmp_err_q <= cmp_err_d;
        end
    end

    assign guess   = guess_q;
    assign result  = result_q;
    assign steps   = steps_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cmp_err = cmp_err_q;

endmodule
